// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Holds the requester count, select width, FSM states and a one-hot helper.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_GAP
  } state_e;

  function automatic logic [0:N_REQ-1] to_onehot(input logic [SEL_W-1:0] idx);
    logic [0:N_REQ-1] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at ptr, ptr+1, ... (mod N_REQ).
// One instance is shared by the idle decision and the back-to-back handover.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [0:N_REQ-1] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    // Scan from the farthest offset down so the nearest hit is the one kept.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a 4:1 mux with bounded hold time and optional dead gap.
// All outputs are registered; sel holds its last value while nobody owns the mux.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int GAP      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:N_REQ-1] req,
  output logic [0:N_REQ-1] grant,
  output logic [0:SEL_W-1] sel,
  output logic             valid,
  output logic             expired
);

  localparam int              HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam logic [3:0]      GAP_LIM  = 4'(GAP);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [0:N_REQ-1]   grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               expired_q, expired_d;

  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

  // While owning, the search must already start past the current owner.
  assign pick_ptr = (state_q == ST_OWN) ? owner_q + SEL_W'(1) : ptr_q;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    expired_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_OWN;
          owner_d    = pick_idx;
          hold_cnt_d = HOLD_W'(1);
        end
      end
      ST_OWN: begin
        if (!req[owner_q] || hold_cnt_q == HOLD_LIM) begin
          expired_d = req[owner_q];
          ptr_d     = owner_q + SEL_W'(1);
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = 4'd1;
          end else if (pick_found) begin
            owner_d    = pick_idx;
            hold_cnt_d = HOLD_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LIM) state_d = ST_IDLE;
        else                      gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_d == ST_OWN);
    grant_d = valid_d ? to_onehot(owner_d) : '0;
    sel_d   = valid_d ? owner_d : sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
    end
  end

  assign grant   = grant_q;
  assign valid   = valid_q;
  assign expired = expired_q;
  // sel is declared ascending; map bit-by-bit so sel[1] stays the index MSB.
  assign sel[0]  = sel_q[0];
  assign sel[1]  = sel_q[1];

endmodule
